// File: rtl/bip_control.sv
// Instruction-sequencing control for the BIP accumulator CPU: PC, fetch/decode FSM and datapath strobes.
// Each instruction takes 3 cycles (4 for memory reads; HLT parks in HALT). The FSM never stalls.
module bip_control #(
  parameter int PC_WIDTH      = 11,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_start,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] i_instr,
  output logic [PC_WIDTH-1:0]                   o_pc,
  output logic [OPERAND_WIDTH-1:0]              o_operand,
  output logic [1:0]                            o_sel_a,
  output logic                                  o_sel_b,
  output logic                                  o_write_acc,
  output logic                                  o_operation,
  output logic                                  o_mem_wr,
  output logic                                  o_halted,
  output logic [COUNT_WIDTH-1:0]                o_instr_count
);

  localparam int INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEMRD  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  logic [2:0]               state;
  logic [PC_WIDTH-1:0]      pc;
  logic [INSTR_WIDTH-1:0]   ir;
  logic [COUNT_WIDTH-1:0]   count;
  logic [OPCODE_WIDTH-1:0]  dec_op;
  logic [OPCODE_WIDTH-1:0]  ir_op;
  logic                     acc_wr;
  logic                     mem_wr;

  assign dec_op = i_instr[INSTR_WIDTH-1:OPERAND_WIDTH];
  assign ir_op  = ir[INSTR_WIDTH-1:OPERAND_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE:   if (i_start) state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir <= i_instr;
          if (dec_op == OP_HLT)
            state <= S_HALT;
          else if (dec_op == OP_LD || dec_op == OP_ADD || dec_op == OP_SUB)
            state <= S_MEMRD;
          else
            state <= S_EXEC;
        end
        S_MEMRD:  state <= S_EXEC;
        S_EXEC: begin
          pc    <= pc + 1'b1;
          if (count != '1) count <= count + 1'b1;
          state <= S_FETCH;
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Selects follow ir continuously; only the strobes are qualified by EXEC.
  always_comb begin
    o_sel_a     = 2'd0;
    o_sel_b     = 1'b0;
    o_operation = 1'b0;
    acc_wr      = 1'b0;
    mem_wr      = 1'b0;
    case (ir_op)
      OP_STO:  mem_wr = 1'b1;
      OP_LD:   acc_wr = 1'b1;
      OP_LDI:  begin acc_wr = 1'b1; o_sel_a = 2'd1; end
      OP_ADD:  begin acc_wr = 1'b1; o_sel_a = 2'd2; end
      OP_ADDI: begin acc_wr = 1'b1; o_sel_a = 2'd2; o_sel_b = 1'b1; end
      OP_SUB:  begin acc_wr = 1'b1; o_sel_a = 2'd2; o_operation = 1'b1; end
      OP_SUBI: begin acc_wr = 1'b1; o_sel_a = 2'd2; o_sel_b = 1'b1; o_operation = 1'b1; end
      default: ;
    endcase
  end

  // Qualifying with rst keeps a reset landing on EXEC from leaking a strobe.
  assign o_write_acc   = acc_wr && (state == S_EXEC) && rst;
  assign o_mem_wr      = mem_wr && (state == S_EXEC) && rst;
  assign o_pc          = pc;
  assign o_operand     = ir[OPERAND_WIDTH-1:0];
  assign o_halted      = (state == S_HALT);
  assign o_instr_count = count;

endmodule

// File: tb/tb_bip_control.sv
// Bench for bip_control: synchronous ROM model plus an instruction-level reference of cycle timing and strobes.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_instr;
  logic [10:0] o_pc;
  logic [10:0] o_operand;
  logic [1:0]  o_sel_a;
  logic        o_sel_b;
  logic        o_write_acc;
  logic        o_operation;
  logic        o_mem_wr;
  logic        o_halted;
  logic [15:0] o_instr_count;

  logic [15:0] rom [2048];
  int n_vec = 0;
  int n_err = 0;
  int m_pc;
  int m_cnt;

  bip_control dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_instr(i_instr),
    .o_pc(o_pc), .o_operand(o_operand), .o_sel_a(o_sel_a), .o_sel_b(o_sel_b),
    .o_write_acc(o_write_acc), .o_operation(o_operation), .o_mem_wr(o_mem_wr),
    .o_halted(o_halted), .o_instr_count(o_instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) i_instr <= rom[o_pc];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wacc"}, 32'(o_write_acc), 0);
    chk({tag, "_memwr"}, 32'(o_mem_wr), 0);
    chk({tag, "_pc"}, 32'(o_pc), 32'(m_pc));
    chk({tag, "_cnt"}, 32'(o_instr_count), 32'(m_cnt));
    chk({tag, "_halt"}, 32'(o_halted), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_start = 1'($urandom_range(0, 1));
    step();
    step();
    chk("rst_pc", 32'(o_pc), 0);
    chk("rst_opd", 32'(o_operand), 0);
    chk("rst_sela", 32'(o_sel_a), 0);
    chk("rst_selb", 32'(o_sel_b), 0);
    chk("rst_op", 32'(o_operation), 0);
    chk("rst_wacc", 32'(o_write_acc), 0);
    chk("rst_memwr", 32'(o_mem_wr), 0);
    chk("rst_halt", 32'(o_halted), 0);
    chk("rst_cnt", 32'(o_instr_count), 0);
    rst = 1'b1;
    i_start = 1'b0;
    m_pc = 0;
    m_cnt = 0;
    step();
    chk_quiet("idle");
  endtask

  task automatic do_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Walks instructions from a FETCH cycle; i_start is randomised since it must be ignored.
  task automatic run_prog(input int max_instr);
    logic [15:0] ins;
    logic [4:0]  op;
    int          n = 0;
    bit          done = 0;
    bit          exp_wa, exp_mw;
    while (!done && n < max_instr) begin
      ins = rom[m_pc];
      op  = ins[15:11];
      chk_quiet("fetch");
      i_start = 1'($urandom_range(0, 1));
      step();
      chk_quiet("decode");
      i_start = 1'($urandom_range(0, 1));
      step();
      if (op == 5'd0) begin
        chk("hlt_halt", 32'(o_halted), 1);
        chk("hlt_cnt", 32'(o_instr_count), 32'(m_cnt));
        chk("hlt_pc", 32'(o_pc), 32'(m_pc));
        chk("hlt_wacc", 32'(o_write_acc), 0);
        done = 1;
      end else begin
        if (op == 5'd2 || op == 5'd4 || op == 5'd6) begin
          chk("memrd_opd", 32'(o_operand), 32'(ins[10:0]));
          chk_quiet("memrd");
          i_start = 1'($urandom_range(0, 1));
          step();
        end
        exp_wa = (op >= 5'd2 && op <= 5'd7);
        exp_mw = (op == 5'd1);
        chk("exec_wacc", 32'(o_write_acc), 32'(exp_wa));
        chk("exec_memwr", 32'(o_mem_wr), 32'(exp_mw));
        chk("exec_opd", 32'(o_operand), 32'(ins[10:0]));
        chk("exec_pc", 32'(o_pc), 32'(m_pc));
        case (op)
          5'd2: chk("ld_sela", 32'(o_sel_a), 0);
          5'd3: chk("ldi_sela", 32'(o_sel_a), 1);
          5'd4: chk("add_sel", 32'({o_sel_a, o_sel_b, o_operation}), 32'({2'd2, 1'b0, 1'b0}));
          5'd5: chk("addi_sel", 32'({o_sel_a, o_sel_b, o_operation}), 32'({2'd2, 1'b1, 1'b0}));
          5'd6: chk("sub_sel", 32'({o_sel_a, o_sel_b, o_operation}), 32'({2'd2, 1'b0, 1'b1}));
          5'd7: chk("subi_sel", 32'({o_sel_a, o_sel_b, o_operation}), 32'({2'd2, 1'b1, 1'b1}));
          default: ;
        endcase
        i_start = 1'($urandom_range(0, 1));
        step();
        m_pc  = (m_pc + 1) % 2048;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        n++;
      end
    end
    i_start = 1'b0;
  endtask

  initial begin
    logic [4:0] rop;
    rst = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;

    // LDI 5, ADDI 3, STO 7, HLT; then i_start while halted
    rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0807; rom[3] = 16'h0000;
    do_reset();
    do_start();
    run_prog(10);
    chk("p1_halted", 32'(o_halted), 1);
    chk("p1_count", 32'(o_instr_count), 3);
    i_start = 1'b1;
    step(); step(); step();
    i_start = 1'b0;
    chk("halt_start_halted", 32'(o_halted), 1);
    chk("halt_start_pc", 32'(o_pc), 3);

    // LD 0x010, SUB 0x011, HLT
    rom[0] = 16'h1010; rom[1] = 16'h3011; rom[2] = 16'h0000;
    do_reset();
    do_start();
    run_prog(10);
    chk("p2_count", 32'(o_instr_count), 2);

    // reserved opcode as NOP
    rom[0] = 16'hF800; rom[1] = 16'h0000;
    do_reset();
    do_start();
    run_prog(1);
    chk("nop_pc", 32'(o_pc), 1);
    chk("nop_cnt", 32'(o_instr_count), 1);

    // reset landing in MEMRD of ADD
    rom[0] = 16'h2005;
    do_reset();
    do_start();
    step();
    step();
    chk("mid_memrd_opd", 32'(o_operand), 5);
    rst = 1'b0;
    step();
    chk("mid_rst_pc", 32'(o_pc), 0);
    chk("mid_rst_wacc", 32'(o_write_acc), 0);
    chk("mid_rst_opd", 32'(o_operand), 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_idle_wacc", 32'(o_write_acc), 0);
      chk("mid_idle_pc", 32'(o_pc), 0);
    end

    // randomised programs with occasional HLT
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2048; i++) begin
        rop = ($urandom_range(0, 63) == 0) ? 5'd0 :
              (p == 1) ? 5'($urandom_range(1, 8)) : 5'($urandom_range(1, 31));
        rom[i] = {rop, 11'($urandom)};
      end
      do_reset();
      do_start();
      run_prog(300);
    end

    // PC wrap after 2048 LDIs
    for (int i = 0; i < 2048; i++) rom[i] = 16'h1800;
    do_reset();
    do_start();
    run_prog(2048);
    chk("wrap_pc", 32'(o_pc), 0);
    chk("wrap_cnt", 32'(o_instr_count), 2048);
    run_prog(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
